// File: rtl/regfile_wb_pkg.sv
// Shared constants, FSM state type and address helpers for the regfile write-port controller.
package regfile_wb_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int REG_IDX_W   = 5;
  localparam int NUM_ENTRIES = 256;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Architectural register index lives in the low bits; the upper bits select the hart.
  function automatic logic [REG_IDX_W-1:0] reg_idx(input logic [ADDR_W-1:0] addr);
    return addr[REG_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/regfile_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr_i, wrapping modulo N.
module regfile_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o,
  output logic                 any_grant_o
);

  localparam int PW = $clog2(N);

  always_comb begin
    int pos;
    logic [PW-1:0] p;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    for (int off = 1; off <= N; off++) begin
      pos = int'(ptr_i) + off;
      pos = (pos >= N) ? (pos - N) : pos;
      p   = PW'(pos);
      if (!any_grant_o && valid_i[p]) begin
        grant_o[p]  = 1'b1;
        grant_idx_o = p;
        any_grant_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port controller: round-robin writeback arbitration, x0 write drop, full clear sequencer.
// Optional per-requester grant/stall counters enabled by REGFILE_WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = regfile_wb_pkg::ADDR_W,
  parameter int DATA_W    = regfile_wb_pkg::DATA_W,
  parameter int REG_IDX_W = regfile_wb_pkg::REG_IDX_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      clear_req,
  output logic                      clear_busy,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      rf_wren
`ifdef REGFILE_WB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     stat_grants,
  output logic [NUM_REQ*32-1:0]     stat_stalls
`endif
);

  import regfile_wb_pkg::*;

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(NUM_ENTRIES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wren_q, wren_d;
  logic                busy_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [PW-1:0]       pick_idx;
  logic                pick_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  regfile_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid_i     (req_valid),
    .ptr_i       (rr_q),
    .grant_o     (pick_grant),
    .grant_idx_o (pick_idx),
    .any_grant_o (pick_any)
  );

  assign sel_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[pick_idx*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wren_d    = 1'b0;
    req_ready = '0;
    case (state_q)
      CLEAR: begin
        wren_d  = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ENTRY) state_d = RUN;
      end
      RUN: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (pick_any) begin
          // x0 writes are consumed like any other grant but never reach the array
          req_ready = pick_grant;
          rr_d      = pick_idx;
          waddr_d   = sel_addr;
          wdata_d   = sel_data;
          wren_d    = (reg_idx(sel_addr) != '0);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // clear_busy lags the state by one cycle so it tracks the clear writes seen on the output stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rr_q    <= PW'(NUM_REQ - 1);
      waddr_q <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      busy_q  <= (state_q == CLEAR);
    end
  end

  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign rf_wren    = wren_q;
  assign clear_busy = busy_q;

`ifdef REGFILE_WB_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grants_q, stalls_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grants_q[i] != 32'hFFFF_FFFF))
          grants_q[i] <= grants_q[i] + 32'd1;
        if (req_valid[i] && !req_ready[i] && (stalls_q[i] != 32'hFFFF_FFFF))
          stalls_q[i] <= stalls_q[i] + 32'd1;
      end
    end
  end

  assign stat_grants = grants_q;
  assign stat_stalls = stalls_q;
`endif

endmodule
